// File: rtl/pattern_checker_pkg.sv
// Shared types and defaults for the pattern checker: FSM encoding, default
// strobe period and resync threshold, and the counter/datapath widths.
package pattern_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_t;

  localparam int DEF_STROBE_PERIOD = 25;
  localparam int DEF_RESYNC_THRESH = 4;

  localparam int DATA_W     = 16;
  localparam int WORD_CNT_W = 32;
  localparam int ERR_CNT_W  = 16;
  localparam int TIMER_W    = 8;
  localparam int MISS_W     = 8;

endpackage

// File: rtl/pattern_checker_strobe_interval_timer.sv
// Measures clk cycles between consecutive strobes, saturating at all-ones.
// The interval is reported on a strobe only once an earlier strobe has armed it.
module strobe_interval_timer
  import pattern_checker_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               strobe,
  output logic               interval_valid,
  output logic [TIMER_W-1:0] interval_value
);

  logic [TIMER_W-1:0] count;
  logic               armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      armed <= 1'b0;
    end else if (!run) begin
      count <= '0;
      armed <= 1'b0;
    end else if (strobe) begin
      count <= TIMER_W'(1);
      armed <= 1'b1;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign interval_valid = strobe & armed & run;
  assign interval_value = count;

endmodule

// File: rtl/pattern_checker.sv
// Checks an incrementing 16-bit test word stream, tracking lock, counts and errors.
// Optional strobe-interval checking is built when GAP_CHECK_EN is defined.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int STROBE_PERIOD = DEF_STROBE_PERIOD,
  parameter int RESYNC_THRESH = DEF_RESYNC_THRESH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iRunStart,
  input  logic                  iData_en,
  input  logic [DATA_W-1:0]     iData,
  input  logic                  iClear,
  output logic                  oLocked,
  output logic [WORD_CNT_W-1:0] oWordCount,
  output logic [ERR_CNT_W-1:0]  oErrorCount,
  output logic [ERR_CNT_W-1:0]  oGapErrCount,
  output logic [DATA_W-1:0]     oLastBad,
  output logic                  oErrPulse
);

  // Timer saturates at 255, so larger periods could never be matched.
  if (STROBE_PERIOD < 1 || STROBE_PERIOD > 255) begin : g_bad_period
    $error("pattern_checker: STROBE_PERIOD must be 1..255");
  end
  if (RESYNC_THRESH < 1 || RESYNC_THRESH > 255) begin : g_bad_thresh
    $error("pattern_checker: RESYNC_THRESH must be 1..255");
  end

  state_t                  state;
  logic [DATA_W-1:0]       expected;
  logic [MISS_W-1:0]       miss_cnt;
  logic                    locked;
  logic [WORD_CNT_W-1:0]   word_count;
  logic [ERR_CNT_W-1:0]    error_count;
  logic [DATA_W-1:0]       last_bad;
  logic                    err_pulse;

  logic take;
  logic data_err;
  logic gap_err;

  assign take     = iRunStart & iData_en & (state != ST_IDLE);
  assign data_err = take & (state == ST_TRACK) & (iData != expected);

`ifdef GAP_CHECK_EN
  logic               interval_valid;
  logic [TIMER_W-1:0] interval_value;
  logic [ERR_CNT_W-1:0] gap_count;

  strobe_interval_timer u_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (iRunStart & (state != ST_IDLE)),
    .strobe         (iData_en),
    .interval_valid (interval_valid),
    .interval_value (interval_value)
  );

  assign gap_err = take & (state == ST_TRACK) & interval_valid &
                   (interval_value != TIMER_W'(STROBE_PERIOD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_count <= '0;
    end else if (iClear) begin
      gap_count <= '0;
    end else if (gap_err && gap_count != '1) begin
      gap_count <= gap_count + 1'b1;
    end
  end

  assign oGapErrCount = gap_count;
`else
  assign gap_err      = 1'b0;
  assign oGapErrCount = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      expected    <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      word_count  <= '0;
      error_count <= '0;
      last_bad    <= '0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= data_err | gap_err;

      if (!iRunStart) begin
        state  <= ST_IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ACQUIRE;
          ST_ACQUIRE: begin
            if (iData_en) begin
              expected <= iData + 1'b1;
              miss_cnt <= '0;
              state    <= ST_TRACK;
              locked   <= 1'b1;
            end
          end
          ST_TRACK: begin
            if (iData_en) begin
              // On a match iData equals expected, so both cases reseed from iData.
              expected <= iData + 1'b1;
              if (data_err) begin
                if (miss_cnt == MISS_W'(RESYNC_THRESH - 1)) begin
                  state    <= ST_ACQUIRE;
                  locked   <= 1'b0;
                  miss_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + 1'b1;
                end
              end else begin
                miss_cnt <= '0;
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      if (iClear) begin
        word_count  <= '0;
        error_count <= '0;
        last_bad    <= '0;
      end else begin
        if (take && word_count != '1) word_count <= word_count + 1'b1;
        if (data_err) begin
          if (error_count != '1) error_count <= error_count + 1'b1;
          last_bad <= iData;
        end
      end
    end
  end

  assign oLocked     = locked;
  assign oWordCount  = word_count;
  assign oErrorCount = error_count;
  assign oLastBad    = last_bad;
  assign oErrPulse   = err_pulse;

endmodule

// File: tb/tb_pattern_checker.sv
// Directed, table-driven bench for pattern_checker with hand-computed expectations,
// plus hand-written reset and idle-strobe sequences.
module tb_pattern_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iRunStart = 1'b0;
  logic        iData_en = 1'b0;
  logic [15:0] iData = '0;
  logic        iClear = 1'b0;
  logic        oLocked;
  logic [31:0] oWordCount;
  logic [15:0] oErrorCount;
  logic [15:0] oGapErrCount;
  logic [15:0] oLastBad;
  logic        oErrPulse;

`ifdef GAP_CHECK_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  pattern_checker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .iRunStart    (iRunStart),
    .iData_en     (iData_en),
    .iData        (iData),
    .iClear       (iClear),
    .oLocked      (oLocked),
    .oWordCount   (oWordCount),
    .oErrorCount  (oErrorCount),
    .oGapErrCount (oGapErrCount),
    .oLastBad     (oLastBad),
    .oErrPulse    (oErrPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          restart;
    bit          clr;
    int          gap;
    logic [15:0] data;
    bit          exp_lock;
    logic [31:0] exp_words;
    logic [15:0] exp_errs;
    logic [15:0] exp_last;
    bit          derr;
    bit          gviol;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_gaps = '0;

  function automatic void add(bit restart, bit clr, int gap, logic [15:0] data, bit lock,
                              logic [31:0] words, logic [15:0] errs, logic [15:0] last,
                              bit derr, bit gviol);
    vec_t v;
    v.restart = restart; v.clr = clr; v.gap = gap; v.data = data;
    v.exp_lock = lock; v.exp_words = words; v.exp_errs = errs; v.exp_last = last;
    v.derr = derr; v.gviol = gviol;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    int   wait_n;

    // Phase A: 0..99 at the nominal period; the first strobe is taken in ACQUIRE.
    add(0, 0, 2, 16'd0, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i < 100; i++) add(0, 0, 25, 16'(i), 1, 32'(i + 1), 0, 0, 0, 0);
    // Clear together with a matching strobe: counts zero, expected still advances.
    add(0, 1, 25, 16'd100, 1, 0, 0, 0, 0, 0);
    add(0, 0, 25, 16'd101, 1, 1, 0, 0, 0, 0);
    // Restart then 9(seed),10,11,12,40,41: single mismatch at 40.
    add(1, 0, 25, 16'd9,  1, 2, 0, 0, 0, 0);
    add(0, 0, 25, 16'd10, 1, 3, 0, 0, 0, 0);
    add(0, 0, 25, 16'd11, 1, 4, 0, 0, 0, 0);
    add(0, 0, 25, 16'd12, 1, 5, 0, 0, 0, 0);
    add(0, 0, 25, 16'd40, 1, 6, 1, 16'd40, 1, 0);
    add(0, 0, 25, 16'd41, 1, 7, 1, 16'd40, 0, 0);
    // Four consecutive misses force re-acquisition; 7 relocks, 8 matches.
    add(0, 0, 25, 16'd5,  1, 8,  2, 16'd5,  1, 0);
    add(0, 0, 25, 16'd9,  1, 9,  3, 16'd9,  1, 0);
    add(0, 0, 25, 16'd20, 1, 10, 4, 16'd20, 1, 0);
    add(0, 0, 25, 16'd3,  0, 11, 5, 16'd3,  1, 0);
    add(0, 0, 25, 16'd7,  1, 12, 5, 16'd3,  0, 0);
    add(0, 0, 25, 16'd8,  1, 13, 5, 16'd3,  0, 0);
    // Wrap-around across 16'hFFFF.
    add(1, 0, 25, 16'hFFFD, 1, 14, 5, 16'd3, 0, 0);
    add(0, 0, 25, 16'hFFFE, 1, 15, 5, 16'd3, 0, 0);
    add(0, 0, 25, 16'hFFFF, 1, 16, 5, 16'd3, 0, 0);
    add(0, 0, 25, 16'h0000, 1, 17, 5, 16'd3, 0, 0);
    add(0, 0, 25, 16'h0001, 1, 18, 5, 16'd3, 0, 0);
    // One short interval (24 cycles) with correct data.
    add(0, 0, 24, 16'h0002, 1, 19, 5, 16'd3, 0, 1);
    add(0, 0, 25, 16'h0003, 1, 20, 5, 16'd3, 0, 0);

    #12;
    chk("reset_locked", 32'(oLocked), 0);
    chk("reset_words",  oWordCount, 0);
    chk("reset_errs",   32'(oErrorCount), 0);
    chk("reset_gaps",   32'(oGapErrCount), 0);
    chk("reset_last",   32'(oLastBad), 0);
    chk("reset_pulse",  32'(oErrPulse), 0);

    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); iRunStart = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wait_n = v.gap - 2;
      if (v.restart) begin
        iRunStart = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_idle_locked", i), 32'(oLocked), 0);
        chk($sformatf("v%0d_idle_words", i), oWordCount, vecs[i-1].exp_words);
        iRunStart = 1'b1;
        wait_n--;
      end
      repeat (wait_n) @(negedge clk);
      iData = v.data; iData_en = 1'b1; iClear = v.clr;
      @(negedge clk);
      iData_en = 1'b0; iClear = 1'b0;
      if (GAP_ON && v.gviol) exp_gaps++;
      chk($sformatf("v%0d_locked", i), 32'(oLocked), 32'(v.exp_lock));
      chk($sformatf("v%0d_words", i), oWordCount, v.exp_words);
      chk($sformatf("v%0d_errs", i), 32'(oErrorCount), 32'(v.exp_errs));
      chk($sformatf("v%0d_gaps", i), 32'(oGapErrCount), 32'(exp_gaps));
      chk($sformatf("v%0d_last", i), 32'(oLastBad), 32'(v.exp_last));
      chk($sformatf("v%0d_pulse", i), 32'(oErrPulse), 32'(v.derr | (GAP_ON & v.gviol)));
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), 32'(oErrPulse), 0);
    end

    // Asynchronous reset while tracking clears everything before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_locked", 32'(oLocked), 0);
    chk("arst_words",  oWordCount, 0);
    chk("arst_errs",   32'(oErrorCount), 0);
    chk("arst_gaps",   32'(oGapErrCount), 0);
    chk("arst_last",   32'(oLastBad), 0);
    chk("arst_pulse",  32'(oErrPulse), 0);

    // Strobes while idle are ignored.
    iRunStart = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    iData = 16'd5; iData_en = 1'b1;
    @(negedge clk); iData_en = 1'b0;
    @(negedge clk);
    chk("idle_strobe_words",  oWordCount, 0);
    chk("idle_strobe_locked", 32'(oLocked), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_checker.md
PATTERN_CHECKER -- requirements
Module: pattern_checker

Interface
REQ-001 SHALL have parameter STROBE_PERIOD, default 25, expected clk cycles between consecutive iData_en pulses.
REQ-002 SHALL have parameter RESYNC_THRESH, default 4, consecutive mismatches that force re-acquisition.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iRunStart  input  1  enable; low returns the checker to IDLE.
REQ-006 SHALL have port iData_en  input  1  single-cycle strobe qualifying iData.
REQ-007 SHALL have port iData  input  16  incrementing test word from the generator.
REQ-008 SHALL have port iClear  input  1  synchronous clear of all counters and sticky flags.
REQ-009 SHALL have port oLocked  output  1  high while in TRACK.
REQ-010 SHALL have port oWordCount  output  32  accepted strobes since clear, saturating.
REQ-011 SHALL have port oErrorCount  output  16  data mismatches since clear, saturating.
REQ-012 SHALL have port oGapErrCount  output  16  interval violations since clear, saturating.
REQ-013 SHALL have port oLastBad  output  16  iData of the most recent mismatch.
REQ-014 SHALL have port oErrPulse  output  1  one-cycle pulse per mismatch or gap violation.

Function
REQ-015 SHALL implement states IDLE, ACQUIRE, TRACK.
- IDLE: iRunStart=1 -> ACQUIRE.
- ACQUIRE: first strobe seeds expected = iData+1 (mod 2^16) -> TRACK.
REQ-016 In TRACK, each strobe SHALL compare iData to expected; match: expected += 1, miss counter cleared; mismatch: oErrorCount += 1, oLastBad = iData, oErrPulse next cycle, expected = iData+1, miss counter += 1.
REQ-017 When the miss counter reaches RESYNC_THRESH, SHALL go to ACQUIRE, oLocked low.
REQ-018 Expected 16'hFFFF followed by 16'h0000 SHALL be a match (wrap-around).
REQ-019 oWordCount SHALL increment on every strobe in ACQUIRE or TRACK; strobes in IDLE are ignored.
REQ-020 All counts SHALL saturate at all-ones, never wrap.
REQ-021 oErrPulse SHALL be one cycle, registered, one cycle after the offending strobe; data and gap errors on the same strobe give one pulse, both counters increment.
REQ-022 iRunStart low in any state SHALL go to IDLE next cycle; counters hold.
REQ-023 iClear SHALL zero all counters and oLastBad next cycle, no state change; iClear and a strobe in the same cycle: clear wins, strobe not counted, but data compare still updates expected.
REQ-024 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 reset_n low SHALL asynchronously set state IDLE, oLocked=0, all counts=0, oLastBad=0, oErrPulse=0, expected=0, interval timer=0.

Configuration
REQ-026 With GAP_CHECK_EN defined, SHALL time cycles between strobes in TRACK; interval != STROBE_PERIOD increments oGapErrCount and pulses oErrPulse; timer restarts on each strobe, saturates at 255; first interval after ACQUIRE is checked.
REQ-027 Without GAP_CHECK_EN, the timer SHALL be absent and oGapErrCount tied to 0.

Structure
REQ-028 State encoding, default STROBE_PERIOD and RESYNC_THRESH, and count widths SHALL reside in shared package pattern_checker_pkg.
REQ-029 Interval timing SHALL be sub-module strobe_interval_timer (strobe in, interval valid/value out), instantiated only under GAP_CHECK_EN.

Verification
REQ-030 Run, strobes every 25 cycles carrying 0..99 -> oLocked=1 after first, oWordCount=100, oErrorCount=0, oGapErrCount=0.
REQ-031 Sequence 10,11,12,40,41 -> oErrorCount=1, oLastBad=40, one oErrPulse, oLocked stays 1.
REQ-032 Four consecutive non-sequential words 5,9,20,3 after lock -> oErrorCount=4, oLocked=0 after fourth, next strobe 7 relocks, 8 then matches.
REQ-033 Words 16'hFFFE,16'hFFFF,16'h0000 -> no errors.
REQ-034 GAP_CHECK_EN, one interval of 24 cycles -> oGapErrCount=1, oErrorCount=0; without macro -> oGapErrCount=0.
REQ-035 reset_n low mid-TRACK -> all outputs 0 immediately; iClear with concurrent strobe -> oWordCount=0.
